// File: rtl/label_allocator.sv
// label_allocator: feeds the label table with label definitions.
// Wipes the table, checks redefinition, allocates data words.
module label_allocator #(
   parameter int LBID_W    = 12,
   parameter int MEM_WORDS = 65536,
   parameter int DATA_BASE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [LBID_W-1:0] req_lbid,
   input  logic [7:0]        req_typ,
   input  logic [15:0]       req_count,
   input  logic [15:0]       req_pc,
   output logic [LBID_W-1:0] chk_lbid,
   input  logic [7:0]        chk_typ,
   output logic [LBID_W-1:0] lbidw,
   output logic [7:0]        typw,
   output logic [15:0]       basew,
   output logic [15:0]       countw,
   output logic              we,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic [16:0]       alloc_ptr
);

   localparam logic [2:0] S_CLEAR = 3'd0;
   localparam logic [2:0] S_IDLE  = 3'd1;
   localparam logic [2:0] S_CHECK = 3'd2;
   localparam logic [2:0] S_CALC  = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;

   localparam logic [LBID_W-1:0] IDX_LAST = '1;
   localparam logic [17:0]       MEM_LIM  = 18'(MEM_WORDS);
   localparam logic [16:0]       BASE     = 17'(DATA_BASE);

   logic [2:0]        state;
   logic              armed;
   logic [LBID_W-1:0] idx;
   logic [LBID_W-1:0] q_lbid;
   logic [7:0]        q_typ;
   logic [15:0]       q_count;
   logic [15:0]       q_pc;
   logic [16:0]       q_words;

   logic [2:0]  sh;
   logic        typ_ok;
   logic        is_code;
   logic [16:0] words;
   logic [17:0] ptr_end;
   logic        oom;

   // Decode the captured type into log2(elements per word).
   always_comb begin
      sh      = 3'd0;
      typ_ok  = 1'b1;
      is_code = 1'b0;
      unique case (q_typ)
         8'h01, 8'h06, 8'h07: sh = 3'd0;
         8'h04, 8'h05:        sh = 3'd1;
         8'h02, 8'h03:        sh = 3'd2;
         8'h08, 8'h09:        sh = 3'd3;
         8'h0A, 8'h0B:        sh = 3'd4;
         8'h0C, 8'h0D:        sh = 3'd5;
         8'h86:               is_code = 1'b1;
         default:             typ_ok = 1'b0;
      endcase
   end

   // Word count rounded up, and the memory bound check.
   always_comb begin
      words = ({1'b0, q_count} + ((17'd1 << sh) - 17'd1)) >> sh;
      if (is_code)
         words = 17'd0;
      ptr_end = {1'b0, alloc_ptr} + {1'b0, words};
      oom     = !is_code && (ptr_end > MEM_LIM);
   end

   // Sequencer: wipe, accept, check, size, write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_CLEAR;
         armed     <= 1'b0;
         idx       <= '0;
         alloc_ptr <= BASE;
         q_lbid    <= '0;
         q_typ     <= '0;
         q_count   <= '0;
         q_pc      <= '0;
         q_words   <= '0;
      end else if (!armed) begin
         armed <= 1'b1;
      end else begin
         unique case (state)
            S_CLEAR: begin
               if (clr) begin
                  idx       <= '0;
                  alloc_ptr <= BASE;
               end else begin
                  idx <= idx + 1'b1;
                  if (idx == IDX_LAST)
                     state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (clr) begin
                  state     <= S_CLEAR;
                  idx       <= '0;
                  alloc_ptr <= BASE;
               end else if (req_valid) begin
                  q_lbid  <= req_lbid;
                  q_typ   <= req_typ;
                  q_count <= req_count;
                  q_pc    <= req_pc;
                  state   <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (chk_typ != 8'h00)
                  state <= S_IDLE;
               else
                  state <= S_CALC;
            end
            S_CALC: begin
               if (!typ_ok || oom) begin
                  state <= S_IDLE;
               end else begin
                  q_words <= words;
                  state   <= S_WRITE;
               end
            end
            S_WRITE: begin
               alloc_ptr <= alloc_ptr + q_words;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Table port and status outputs decoded from state.
   always_comb begin
      req_ready = 1'b0;
      lbidw     = '0;
      typw      = 8'h00;
      basew     = 16'h0000;
      countw    = 16'h0000;
      we        = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      err_code  = 2'd0;
      chk_lbid  = q_lbid;
      busy      = (state != S_IDLE);
      if (armed) begin
         unique case (state)
            S_CLEAR: begin
               we    = 1'b1;
               lbidw = idx;
            end
            S_IDLE: req_ready = 1'b1;
            S_CHECK: begin
               if (chk_typ != 8'h00) begin
                  done     = 1'b1;
                  err      = 1'b1;
                  err_code = 2'd1;
               end
            end
            S_CALC: begin
               if (!typ_ok) begin
                  done     = 1'b1;
                  err      = 1'b1;
                  err_code = 2'd2;
               end else if (oom) begin
                  done     = 1'b1;
                  err      = 1'b1;
                  err_code = 2'd3;
               end
            end
            S_WRITE: begin
               we     = 1'b1;
               done   = 1'b1;
               lbidw  = q_lbid;
               typw   = q_typ;
               basew  = is_code ? q_pc : alloc_ptr[15:0];
               countw = is_code ? 16'h0000 : q_count;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_label_allocator.sv
// tb_label_allocator: directed bench for label_allocator.
// A small typ table model answers the redefinition reads.
module tb_label_allocator;

   logic        clk;
   logic        rst_n;
   logic        clr;
   logic        req_valid;
   logic        req_ready;
   logic [11:0] req_lbid;
   logic [7:0]  req_typ;
   logic [15:0] req_count;
   logic [15:0] req_pc;
   logic [11:0] chk_lbid;
   logic [7:0]  chk_typ;
   logic [11:0] lbidw;
   logic [7:0]  typw;
   logic [15:0] basew;
   logic [15:0] countw;
   logic        we;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [16:0] alloc_ptr;

   int vectors;
   int miscompares;

   logic [7:0] tmem [0:4095];
   logic       init_done = 1'b0;

   int          r_lat;
   logic        r_done;
   logic        r_we;
   logic        r_err;
   logic [1:0]  r_ec;
   logic [11:0] r_lbid;
   logic [7:0]  r_typ;
   logic [15:0] r_base;
   logic [15:0] r_count;
   logic        r_ready;
   logic [16:0] r_ptr;

   label_allocator #(
      .LBID_W(12),
      .MEM_WORDS(8),
      .DATA_BASE(0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .clr(clr),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_lbid(req_lbid),
      .req_typ(req_typ),
      .req_count(req_count),
      .req_pc(req_pc),
      .chk_lbid(chk_lbid),
      .chk_typ(chk_typ),
      .lbidw(lbidw),
      .typw(typw),
      .basew(basew),
      .countw(countw),
      .we(we),
      .busy(busy),
      .done(done),
      .err(err),
      .err_code(err_code),
      .alloc_ptr(alloc_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Table model: starts with garbage so the wipe matters.
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 4096; i++)
            tmem[i] <= 8'hAA;
         init_done <= 1'b1;
      end else if (we) begin
         tmem[lbidw] <= typw;
      end
   end

   assign chk_typ = tmem[chk_lbid];

   task automatic send(input logic [11:0] l, input logic [7:0] t,
                       input logic [15:0] c, input logic [15:0] p);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         vectors++;
         miscompares++;
         $display("FAIL send_wait_ready: req_ready=%b required 1", req_ready);
      end
      req_valid = 1'b1;
      req_lbid  = l;
      req_typ   = t;
      req_count = c;
      req_pc    = p;
      @(negedge clk);
      req_valid = 1'b0;
      r_lat = 1; r_done = 0; r_we = 0; r_err = 0; r_ec = 0;
      r_lbid = 0; r_typ = 0; r_base = 0; r_count = 0;
      while (!r_done && r_lat < 10) begin
         if (we === 1'b1) begin
            r_we = 1; r_lbid = lbidw; r_typ = typw;
            r_base = basew; r_count = countw;
         end
         if (done === 1'b1) begin
            r_done = 1; r_err = err; r_ec = err_code;
         end else begin
            @(negedge clk);
            r_lat++;
         end
      end
      if (!r_done) begin
         vectors++;
         miscompares++;
         $display("FAIL send_done_timeout: no done within %0d cycles", r_lat);
      end
      @(negedge clk);
      r_ready = req_ready;
      r_ptr   = alloc_ptr;
   endtask

   task automatic test_wipe(input string tag);
      int n;
      int cnt;
      int bad;
      int nz;
      n = 0;
      while (we !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      cnt = 0;
      bad = 0;
      while (we === 1'b1 && cnt < 5000) begin
         if (lbidw !== cnt[11:0] || typw !== 8'h00 || basew !== 16'h0
             || countw !== 16'h0 || req_ready !== 1'b0)
            bad++;
         cnt++;
         @(negedge clk);
      end
      vectors++;
      if (cnt !== 4096) begin
         miscompares++;
         $display("FAIL %s_wipe_len: got %0d cycles required 4096", tag, cnt);
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL %s_wipe_data: %0d bad write cycles required 0", tag, bad);
      end
      vectors++;
      if ({req_ready, busy} !== 2'b10) begin
         miscompares++;
         $display("FAIL %s_ready_after: ready,busy=%b required 10", tag, {req_ready, busy});
      end
      vectors++;
      if (alloc_ptr !== 17'd0) begin
         miscompares++;
         $display("FAIL %s_ptr: alloc_ptr=%0d required 0", tag, alloc_ptr);
      end
      nz = 0;
      for (int i = 0; i < 4096; i++)
         if (tmem[i] !== 8'h00) nz++;
      vectors++;
      if (nz !== 0) begin
         miscompares++;
         $display("FAIL %s_table: %0d nonzero entries required 0", tag, nz);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({we, done, err, err_code, req_ready, lbidw, typw, basew, countw} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: we=%b done=%b err=%b ec=%0d rdy=%b lbidw=%0d",
                  we, done, err, err_code, req_ready, lbidw);
      end
      vectors++;
      if (alloc_ptr !== 17'd0) begin
         miscompares++;
         $display("FAIL reset_ptr: alloc_ptr=%0d required 0", alloc_ptr);
      end
      rst_n = 1'b1;
      test_wipe("reset");
   endtask

   task automatic test_define();
      send(12'd5, 8'h03, 16'd10, 16'h0);
      vectors++;
      if ({r_lat[3:0], r_we, r_err} !== {4'd3, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL def5_timing: lat=%0d we=%b err=%b required 3 1 0", r_lat, r_we, r_err);
      end
      vectors++;
      if ({r_lbid, r_typ, r_base, r_count} !== {12'd5, 8'h03, 16'd0, 16'd10}) begin
         miscompares++;
         $display("FAIL def5_write: lbid=%0d typ=%h base=%0d count=%0d required 5 03 0 10",
                  r_lbid, r_typ, r_base, r_count);
      end
      vectors++;
      if ({r_ready, r_ptr} !== {1'b1, 17'd3}) begin
         miscompares++;
         $display("FAIL def5_after: ready=%b ptr=%0d required 1 3", r_ready, r_ptr);
      end
      send(12'd6, 8'h06, 16'd4, 16'h0);
      vectors++;
      if ({r_we, r_err, r_lbid, r_base, r_count} !== {1'b1, 1'b0, 12'd6, 16'd3, 16'd4}) begin
         miscompares++;
         $display("FAIL def6_write: we=%b err=%b lbid=%0d base=%0d count=%0d required 1 0 6 3 4",
                  r_we, r_err, r_lbid, r_base, r_count);
      end
      vectors++;
      if (r_ptr !== 17'd7) begin
         miscompares++;
         $display("FAIL def6_ptr: alloc_ptr=%0d required 7", r_ptr);
      end
   endtask

   task automatic test_redefine();
      send(12'd5, 8'h03, 16'd10, 16'h0);
      vectors++;
      if ({r_lat[3:0], r_we, r_err, r_ec} !== {4'd1, 1'b0, 1'b1, 2'd1}) begin
         miscompares++;
         $display("FAIL redef: lat=%0d we=%b err=%b ec=%0d required 1 0 1 1",
                  r_lat, r_we, r_err, r_ec);
      end
      vectors++;
      if (r_ptr !== 17'd7) begin
         miscompares++;
         $display("FAIL redef_ptr: alloc_ptr=%0d required 7", r_ptr);
      end
   endtask

   task automatic test_code_and_badtype();
      send(12'd9, 8'h86, 16'd77, 16'h1234);
      vectors++;
      if ({r_we, r_err, r_lbid, r_typ, r_base, r_count}
          !== {1'b1, 1'b0, 12'd9, 8'h86, 16'h1234, 16'h0}) begin
         miscompares++;
         $display("FAIL code9: we=%b err=%b lbid=%0d typ=%h base=%h count=%0d required 1 0 9 86 1234 0",
                  r_we, r_err, r_lbid, r_typ, r_base, r_count);
      end
      vectors++;
      if (r_ptr !== 17'd7) begin
         miscompares++;
         $display("FAIL code9_ptr: alloc_ptr=%0d required 7", r_ptr);
      end
      send(12'd10, 8'h0E, 16'd5, 16'h0);
      vectors++;
      if ({r_lat[3:0], r_we, r_err, r_ec} !== {4'd2, 1'b0, 1'b1, 2'd2}) begin
         miscompares++;
         $display("FAIL badtype: lat=%0d we=%b err=%b ec=%0d required 2 0 1 2",
                  r_lat, r_we, r_err, r_ec);
      end
   endtask

   task automatic test_oom();
      send(12'd11, 8'h0D, 16'd33, 16'h0);
      vectors++;
      if ({r_lat[3:0], r_we, r_err, r_ec, r_ptr} !== {4'd2, 1'b0, 1'b1, 2'd3, 17'd7}) begin
         miscompares++;
         $display("FAIL oom33: lat=%0d we=%b err=%b ec=%0d ptr=%0d required 2 0 1 3 7",
                  r_lat, r_we, r_err, r_ec, r_ptr);
      end
      send(12'd11, 8'h0D, 16'd32, 16'h0);
      vectors++;
      if ({r_we, r_err, r_base, r_count, r_ptr} !== {1'b1, 1'b0, 16'd7, 16'd32, 17'd8}) begin
         miscompares++;
         $display("FAIL fit32: we=%b err=%b base=%0d count=%0d ptr=%0d required 1 0 7 32 8",
                  r_we, r_err, r_base, r_count, r_ptr);
      end
      send(12'd12, 8'h0D, 16'd0, 16'h0);
      vectors++;
      if ({r_we, r_err, r_base, r_count, r_ptr} !== {1'b1, 1'b0, 16'd8, 16'd0, 17'd8}) begin
         miscompares++;
         $display("FAIL zero_at_full: we=%b err=%b base=%0d count=%0d ptr=%0d required 1 0 8 0 8",
                  r_we, r_err, r_base, r_count, r_ptr);
      end
      send(12'd13, 8'h01, 16'd1, 16'h0);
      vectors++;
      if ({r_we, r_err, r_ec, r_ptr} !== {1'b0, 1'b1, 2'd3, 17'd8}) begin
         miscompares++;
         $display("FAIL one_at_full: we=%b err=%b ec=%0d ptr=%0d required 0 1 3 8",
                  r_we, r_err, r_ec, r_ptr);
      end
   endtask

   task automatic test_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      test_wipe("clr");
      send(12'd5, 8'h01, 16'd1, 16'h0);
      vectors++;
      if ({r_we, r_err, r_base, r_ptr} !== {1'b1, 1'b0, 16'd0, 17'd1}) begin
         miscompares++;
         $display("FAIL post_clr_def: we=%b err=%b base=%0d ptr=%0d required 1 0 0 1",
                  r_we, r_err, r_base, r_ptr);
      end
   endtask

   task automatic test_reset_midreq();
      @(negedge clk);
      req_valid = 1'b1;
      req_lbid  = 12'd20;
      req_typ   = 8'h01;
      req_count = 16'd2;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({busy, done, we} !== 3'b100) begin
         miscompares++;
         $display("FAIL midreq_calc: busy,done,we=%b required 100", {busy, done, we});
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({we, done, req_ready, alloc_ptr} !== '0) begin
         miscompares++;
         $display("FAIL midreq_reset: we=%b done=%b rdy=%b ptr=%0d required 0 0 0 0",
                  we, done, req_ready, alloc_ptr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_wipe("midreq");
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      clr         = 1'b0;
      req_valid   = 1'b0;
      req_lbid    = '0;
      req_typ     = '0;
      req_count   = '0;
      req_pc      = '0;
      test_reset();
      test_define();
      test_redefine();
      test_code_and_badtype();
      test_oom();
      test_clr();
      test_reset_midreq();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
